// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle for axi4_lite_slave_regfile.
// The master modport drives requests; the slave modport is the register file side.
interface axi4_lite_slave_regfile_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wstrb, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wstrb, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register file responder with NUM_REGS memory-mapped registers.
// Write address and write data are captured independently into holding
// registers; the write commits on the edge where both are held.
// Optional macro AXI_SLAVE_WRCNT_EN: the last register becomes a read-only
// counter of successful (OKAY) write commits.
module axi4_lite_slave_regfile #(
  parameter int                      DATA_WIDTH    = 32,
  parameter int                      ADDRESS_WIDTH = 32,
  parameter int                      NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi4_lite_slave_regfile_if.slave    s_axi
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDRESS_WIDTH-1:0] NUM_REGS_A = ADDRESS_WIDTH'(NUM_REGS);
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Returns {hit, index}; sub-word address bits are discarded by the shift.
  function automatic logic [IDX_W:0] decode(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] word;
    logic                     hit;
    word = (addr - BASE_ADDR) >> ADDR_LSB;
    hit  = (addr >= BASE_ADDR) && (word < NUM_REGS_A);
    return {hit, word[IDX_W-1:0]};
  endfunction

  // Byte-lane merge of new data into an existing register value.
  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic                     live_q, live_d;
  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     rvalid_q, rvalid_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W:0]   wr_dec, rd_dec;
  logic             wr_hit, wr_ok, rd_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign s_axi.awready = live_q & ~aw_held_q & ~bvalid_q;
  assign s_axi.wready  = live_q & ~w_held_q  & ~bvalid_q;
  assign s_axi.arready = live_q & ~rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid  & s_axi.wready;
  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign commit = aw_held_q & w_held_q;

  assign wr_dec = decode(awaddr_q);
  assign wr_hit = wr_dec[IDX_W];
  assign wr_idx = wr_dec[IDX_W-1:0];
  assign rd_dec = decode(s_axi.araddr);
  assign rd_hit = rd_dec[IDX_W];
  assign rd_idx = rd_dec[IDX_W-1:0];

`ifdef AXI_SLAVE_WRCNT_EN
  // The counter register rejects writes, so only other hits succeed.
  assign wr_ok = wr_hit & (wr_idx != LAST_IDX);
`else
  assign wr_ok = wr_hit;
`endif

  // Next-state logic for both channels and the register bank.
  always_comb begin
    live_d    = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    // Readies are low while both are held, so a commit never overlaps a new handshake.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        regs_d[wr_idx] = apply_strb(regs_q[wr_idx], wdata_q, wstrb_q);
`ifdef AXI_SLAVE_WRCNT_EN
        regs_d[LAST_IDX] = regs_q[LAST_IDX] + DATA_WIDTH'(1);
`endif
      end
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a same-edge commit is not visible yet.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      live_q    <= live_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_lite_slave_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_regfile_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  axi4_lite_slave_regfile #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_axi (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called and returns at a falling edge; bready held high until B completes.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done;
    int t;
    aw_done = 0; w_done = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    t = 0;
    while (!(aw_done && w_done) && t < 20) begin
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      @(negedge clk);
      if (aw_done) bus.awvalid = 1'b0;
      if (w_done) bus.wvalid = 1'b0;
      t++;
    end
    t = 0;
    while (!bus.bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wr_bvalid_seen", bus.bvalid, 1);
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  // Called and returns at a falling edge; checks the one-cycle read latency.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rd_rvalid_latency", bus.rvalid, 1);
    d = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wstrb = 0; bus.wdata = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    rst_n = 1'b1;
    #1 chk("rel_readies_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    @(negedge clk);
    chk("rel_readies_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // AW and W together; latency is one edge after the handshake edge
    bus.awaddr = 32'h4; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    chk("aw_w_held_no_b_yet", bus.bvalid, 0);
    chk("aw_w_held_readies", {bus.awready, bus.wready}, 2'b00);
    @(negedge clk);
    chk("b_after_one_edge", bus.bvalid, 1);
    chk("b_okay", bus.bresp, 2'b00);
    @(negedge clk);
    bus.bready = 0;
    chk("b_cleared", bus.bvalid, 0);
    axi_read(32'h4, rd, rsp);
    chk("rd4_data", rd, 32'hDEADBEEF);
    chk("rd4_resp", rsp, 2'b00);

    // W three cycles ahead of AW, then B backpressure
    bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1;
    @(negedge clk);
    bus.wvalid = 0;
    chk("w_early_held_wready", bus.wready, 0);
    chk("w_early_no_b", bus.bvalid, 0);
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 32'h8; bus.awvalid = 1;
    @(negedge clk);
    bus.awvalid = 0;
    chk("ooo_no_b_before_commit", bus.bvalid, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp_bvalid_held", bus.bvalid, 1);
      chk("bp_bresp_held", bus.bresp, 2'b00);
      chk("bp_readies_low", {bus.awready, bus.wready}, 2'b00);
      @(negedge clk);
    end
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    chk("bp_b_cleared", bus.bvalid, 0);
    chk("bp_readies_back", {bus.awready, bus.wready}, 2'b11);
    axi_read(32'h8, rd, rsp);
    chk("rd8_strobed", rd, 32'h00220044);

    // Zero strobes and unaligned read address
    axi_write(32'h4, 32'h0BADF00D, 4'h0, rsp);
    chk("wstrb0_resp", rsp, 2'b00);
    axi_read(32'h7, rd, rsp);
    chk("wstrb0_unchanged_unaligned", rd, 32'hDEADBEEF);

    // Out of range
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, rsp);
    chk("oor_bresp", rsp, 2'b10);
    axi_read(32'h40, rd, rsp);
    chk("oor_rdata", rd, 0);
    chk("oor_rresp", rsp, 2'b10);
    axi_read(32'h0, rd, rsp);
    chk("oor_reg0_untouched", rd, 0);
    axi_read(32'h8, rd, rsp);
    chk("oor_reg2_untouched", rd, 32'h00220044);

    // Read backpressure, then asynchronous reset mid-wait
    bus.araddr = 32'h4; bus.arvalid = 1; bus.rready = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rbp_rvalid", bus.rvalid, 1);
      chk("rbp_rdata_stable", bus.rdata, 32'hDEADBEEF);
      chk("rbp_arready_low", bus.arready, 0);
      @(negedge clk);
    end
    bus.arvalid = 0;
    #2 rst_n = 0;
    #1 chk("async_rst_rvalid", bus.rvalid, 0);
    chk("async_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    axi_read(32'h0, rd, rsp);
    chk("post_rst_reg0", rd, 0);
    axi_read(32'h4, rd, rsp);
    chk("post_rst_reg1", rd, 0);

`ifdef AXI_SLAVE_WRCNT_EN
    // Write counter: three OKAY writes, one rejected write to the counter
    axi_write(32'h0, 32'h1, 4'hF, rsp);
    chk("cnt_w1", rsp, 2'b00);
    axi_write(32'h4, 32'h2, 4'hF, rsp);
    chk("cnt_w2", rsp, 2'b00);
    axi_write(32'h8, 32'h3, 4'hF, rsp);
    chk("cnt_w3", rsp, 2'b00);
    axi_write(32'h3C, 32'hFFFF, 4'hF, rsp);
    chk("cnt_w4_slverr", rsp, 2'b10);
    axi_read(32'h3C, rd, rsp);
    chk("cnt_value", rd, 32'd3);
    chk("cnt_rresp", rsp, 2'b00);
`else
    // Last register is ordinary read/write storage
    axi_write(32'h3C, 32'hA5A5_5A5A, 4'hF, rsp);
    chk("last_reg_bresp", rsp, 2'b00);
    axi_read(32'h3C, rd, rsp);
    chk("last_reg_data", rd, 32'hA5A5_5A5A);
    chk("last_reg_rresp", rsp, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
AXI4-Lite responder (slave) holding a bank of NUM_REGS memory-mapped registers. It is the target end of the AXI4-Lite master interface. Write address and write data are accepted independently and in either order. Each write completes with one B response and each read with one R beat. Out-of-range accesses return SLVERR.

Parameters:
DATA_WIDTH, 32, data bus width in bits (32 or 64)
ADDRESS_WIDTH, 32, address bus width in bits
NUM_REGS, 16, number of registers; must be a power of two and at least 2
BASE_ADDR, 32'h0000_0000, byte address of register 0

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDRESS_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wstrb  in  DATA_WIDTH/8  byte-lane write strobes
wdata  in  DATA_WIDTH  write data
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response (2'b00 OKAY, 2'b10 SLVERR)
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDRESS_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response (2'b00 OKAY, 2'b10 SLVERR)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- In reset, all registers clear to 0 and the holding flags aw_held and w_held clear.
- Output values in reset: bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=0, wready=0, arready=0.
- A flop live resets to 0 and sets to 1 on the first clk edge after rst_n rises. All readies are gated by live.
- Readies:
  - awready = live & !aw_held & !bvalid
  - wready = live & !w_held & !bvalid
  - arready = live & !rvalid
- AW handshake (awvalid&awready): latch awaddr and set aw_held.
- W handshake (wvalid&wready): latch wdata/wstrb and set w_held.
- AW and W in the same cycle set both flags at once.
- Commit: on the edge where aw_held&w_held are both 1, perform the write, set bvalid=1, load bresp, and clear both flags.
- Write latency: best case, AW and W both handshake at edge N and bvalid rises at edge N+1.
- bvalid and bresp stay stable until bready is sampled high. bvalid then clears on that edge.
- New AW/W are accepted from the following cycle.
- Decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - Hit when addr >= BASE_ADDR and idx < NUM_REGS.
  - Low address bits below word alignment are ignored.
- Write hit: for each lane i, reg[idx] byte i is updated only when wstrb[i]=1. bresp=OKAY.
- wstrb=0 on a hit: no change, bresp=OKAY.
- Write miss: no register changes, bresp=SLVERR.
- Read: on the AR handshake edge, rdata is loaded with reg[idx] (hit, rresp=OKAY) or 0 (miss, rresp=SLVERR), and rvalid is set to 1. Read latency is 1 cycle.
- rdata/rresp are held stable while rvalid=1 and rready=0. rvalid clears on the edge where rready=1.
- Simultaneous write commit and AR handshake to the same register: rdata returns the pre-write value.
- Read and write channels are fully independent. Valids arriving while ready=0 are simply not accepted.
- Reset asserted mid-transaction: pending AW/W/B/R are discarded immediately and no partial write occurs.

Optional Feature:
Macro AXI_SLAVE_WRCNT_EN.
- Defined: register NUM_REGS-1 is a read-only counter, reset 0, width DATA_WIDTH.
  - It increments by 1 on every write commit with bresp=OKAY and wraps from all-ones to 0.
  - A write to NUM_REGS-1 returns SLVERR, does not alter the counter, and is not counted.
  - A read of NUM_REGS-1 returns the count with OKAY.
- Undefined: register NUM_REGS-1 is an ordinary read/write register.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles -> all outputs 0. After release, awready=wready=arready=1 one edge later.
- AW and W together: awaddr=0x4, wdata=0xDEADBEEF, wstrb=4'hF same cycle; bready=1 -> bvalid 1 cycle later with bresp=00. Then read 0x4 -> rvalid next cycle, rdata=0xDEADBEEF, rresp=00.
- Out-of-order channels and backpressure: W (0x8, data 0x11223344, wstrb=4'b0101) 3 cycles before AW; bready=0 for 4 cycles -> bvalid held with awready=wready=0 throughout; read 0x8 returns 0x00220044.
- Out-of-range: write and then read at address 0x40 with NUM_REGS=16 -> bresp=10, rresp=10, rdata=0, no register changed.
- Read backpressure plus reset: rready=0 for 5 cycles -> rdata stable. Then assert rst_n=0 mid-wait -> rvalid=0 immediately, and a read of reg 0 returns 0.
- AXI_SLAVE_WRCNT_EN defined: 3 OKAY writes, then 1 write to 0x3C -> 4th bresp=10; read 0x3C returns 3.
